// File: rtl/snddma_pkg.sv
// snddma_pkg: register map, playback states and byte-packing layout for the DMA-sound controller
package snddma_pkg;
   localparam logic [4:0] SCNTL = 5'd0;
   localparam logic [4:0] SFBH  = 5'd1;
   localparam logic [4:0] SFBM  = 5'd2;
   localparam logic [4:0] SFBL  = 5'd3;
   localparam logic [4:0] SCAH  = 5'd4;
   localparam logic [4:0] SCAM  = 5'd5;
   localparam logic [4:0] SCAL  = 5'd6;
   localparam logic [4:0] SFTH  = 5'd7;
   localparam logic [4:0] SFTM  = 5'd8;
   localparam logic [4:0] SFTL  = 5'd9;
   localparam logic [4:0] SMODE = 5'd16;
   // word-address bit positions of A16 and A8 (bit 0 of a word address is A1)
   localparam int HI_LSB  = 15;
   localparam int MID_LSB = 7;
   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
   // bus view of one byte of a word address: 0 = hi, 1 = mid, 2 = lo
   function automatic logic [7:0] addr_byte(input logic [20:0] w, input logic [1:0] sel);
      return sel == 2'd0 ? {2'b00, w[20:HI_LSB]} :
             sel == 2'd1 ? w[HI_LSB-1:MID_LSB] : {w[MID_LSB-1:0], 1'b0};
   endfunction
endpackage

// File: rtl/snddma_addrreg.sv
// snddma_addrreg: word address assembled from independent hi/mid/lo byte writes
module snddma_addrreg
   import snddma_pkg::*;
(
   input  logic        clk32,
   input  logic        resb,
   input  logic [7:0]  din_i,
   input  logic        we_hi_i,
   input  logic        we_mid_i,
   input  logic        we_lo_i,
   output logic [20:0] addr_o
);
   logic [20:0] addr_q;
   assign addr_o = addr_q;
   // byte-lane writes; bus bits above A21 and A0 have no storage
   always_ff @(posedge clk32 or negedge resb)
      if (!resb) addr_q <= '0;
      else begin
         if (we_hi_i) addr_q[20:HI_LSB] <= din_i[5:0];
         if (we_mid_i) addr_q[HI_LSB-1:MID_LSB] <= din_i;
         if (we_lo_i) addr_q[MID_LSB-1:0] <= din_i[7:1];
      end
endmodule

// File: rtl/snddma_ctrl.sv
// snddma_ctrl: DMA-sound register file and single-shot/repeat frame sequencer
module snddma_ctrl
   import snddma_pkg::*;
#(
   parameter int          AW         = 21,
   parameter logic [1:0]  RESET_MODE = 2'b00
) (
   input  logic          clk32,
   input  logic          resb,
   input  logic          we,
   input  logic          re,
   input  logic [4:0]    a,
   input  logic [7:0]    din,
   input  logic [AW-1:0] snd,
   input  logic          send,
   output logic [7:0]    dout,
   output logic          dout_oe,
   output logic          sndon,
   output logic          sfrep,
   output logic [AW-1:0] sfb,
   output logic [AW-1:0] sft,
   output logic          sframe,
   output logic          sint,
   output logic [1:0]    rate,
   output logic          mono
);
   state_t        state_q;
   logic [AW-1:0] shb, sht, sfb_q, sft_q;
   logic          rep_q, sndon_q, sframe_q, sint_q, mono_q, oe_q;
   logic [1:0]    rate_q;
   logic [7:0]    dout_q, rdata;
   logic          wr_ctl, rep_d;

   assign wr_ctl  = we && a == SCNTL;
   assign rep_d   = wr_ctl ? din[1] : rep_q;
   assign dout    = dout_q;
   assign dout_oe = oe_q;
   assign sndon   = sndon_q;
   assign sfrep   = rep_q;
   assign sfb     = sfb_q;
   assign sft     = sft_q;
   assign sframe  = sframe_q;
   assign sint    = sint_q;
   assign rate    = rate_q;
   assign mono    = mono_q;

   snddma_addrreg u_start (
      .clk32    (clk32),
      .resb     (resb),
      .din_i    (din),
      .we_hi_i  (we && a == SFBH),
      .we_mid_i (we && a == SFBM),
      .we_lo_i  (we && a == SFBL),
      .addr_o   (shb)
   );

   snddma_addrreg u_end (
      .clk32    (clk32),
      .resb     (resb),
      .din_i    (din),
      .we_hi_i  (we && a == SFTH),
      .we_mid_i (we && a == SFTM),
      .we_lo_i  (we && a == SFTL),
      .addr_o   (sht)
   );

   // read-data mux; the counter bytes come from the live address counter
   always_comb begin
      rdata = '0;
      case (a)
         SCNTL:   rdata = {6'b0, rep_q, sndon_q};
         SFBH:    rdata = addr_byte(shb, 2'd0);
         SFBM:    rdata = addr_byte(shb, 2'd1);
         SFBL:    rdata = addr_byte(shb, 2'd2);
         SCAH:    rdata = addr_byte(snd, 2'd0);
         SCAM:    rdata = addr_byte(snd, 2'd1);
         SCAL:    rdata = addr_byte(snd, 2'd2);
         SFTH:    rdata = addr_byte(sht, 2'd0);
         SFTM:    rdata = addr_byte(sht, 2'd1);
         SFTL:    rdata = addr_byte(sht, 2'd2);
         SMODE:   rdata = {mono_q, 5'b0, rate_q};
         default: rdata = '0;
      endcase
   end

   // read data presented for exactly one cycle after the strobe
   always_ff @(posedge clk32 or negedge resb)
      if (!resb) begin
         dout_q <= '0;
         oe_q   <= 1'b0;
      end else begin
         dout_q <= re ? rdata : 8'h00;
         oe_q   <= re;
      end

   // mode register: sample rate and mono select
   always_ff @(posedge clk32 or negedge resb)
      if (!resb) begin
         rate_q <= RESET_MODE;
         mono_q <= 1'b0;
      end else if (we && a == SMODE) begin
         rate_q <= din[1:0];
         mono_q <= din[7];
      end

   // frame sequencer; the load into sfb/sft happens on entry to LOAD and on repeat wrap
   always_ff @(posedge clk32 or negedge resb)
      if (!resb) begin
         state_q  <= IDLE;
         rep_q    <= 1'b0;
         sndon_q  <= 1'b0;
         sframe_q <= 1'b0;
         sint_q   <= 1'b0;
         sfb_q    <= '0;
         sft_q    <= '0;
      end else begin
         rep_q    <= rep_d;
         sframe_q <= 1'b0;
         sint_q   <= 1'b0;
         if (state_q == IDLE) begin
            if (wr_ctl && din[0]) begin
               state_q  <= LOAD;
               sfb_q    <= shb;
               sft_q    <= sht;
               sframe_q <= 1'b1;
               sndon_q  <= 1'b1;
            end
         end else begin
            sint_q <= send;
            if (wr_ctl && !din[0]) begin
               state_q <= IDLE;
               sndon_q <= 1'b0;
            end else if (send && rep_d) begin
               state_q  <= RUN;
               sfb_q    <= shb;
               sft_q    <= sht;
               sframe_q <= 1'b1;
            end else if (send) begin
               state_q <= IDLE;
               sndon_q <= 1'b0;
            end else state_q <= RUN;
         end
      end
endmodule

// File: tb/tb_snddma_ctrl.sv
// tb_snddma_ctrl: directed plus randomized scoreboard bench for snddma_ctrl
module tb_snddma_ctrl;
   localparam logic [1:0] RM = 2'b10;

   typedef struct {int cyc; logic [7:0] v;} rd_t;
   typedef struct {int cyc; logic [20:0] b; logic [20:0] t;} fr_t;
   typedef struct {int cyc; logic on; logic rep; logic mono; logic [1:0] rate; logic [20:0] b; logic [20:0] t;} st_t;

   logic        clk32 = 1'b0, resb = 1'b1, we = 1'b0, re = 1'b0, send = 1'b0;
   logic [4:0]  a = '0;
   logic [7:0]  din = '0;
   logic [20:0] snd = '0, snd_v = '0;
   logic [7:0]  dout;
   logic        dout_oe, sndon, sfrep, sframe, sint, mono;
   logic [20:0] sfb, sft;
   logic [1:0]  rate;

   int  cyc = 0, tests = 0, failed = 0;
   bit  in_rst = 1'b0;
   rd_t rq[$];
   fr_t fq[$];
   int  iq[$];
   st_t sq[$];

   // reference state: shadows kept as byte addresses, frame regs as word addresses
   bit          m_on, m_rep, m_mono;
   logic [1:0]  m_rate;
   logic [21:0] m_shb, m_sht;
   logic [20:0] m_sfb, m_sft;

   snddma_ctrl #(.AW(21), .RESET_MODE(RM)) dut (
      .clk32(clk32), .resb(resb), .we(we), .re(re), .a(a), .din(din), .snd(snd), .send(send),
      .dout(dout), .dout_oe(dout_oe), .sndon(sndon), .sfrep(sfrep), .sfb(sfb), .sft(sft),
      .sframe(sframe), .sint(sint), .rate(rate), .mono(mono)
   );

   always #5 clk32 = ~clk32;
   always @(posedge clk32) cyc <= cyc + 1;

   task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
      end
   endtask

   task automatic flag(input string n);
      tests++;
      failed++;
      $display("FAIL %s (cycle %0d)", n, cyc);
   endtask

   function automatic logic [7:0] rbyte(input logic [21:0] ba, input int k);
      if (k == 0) return (ba >> 16) & 22'h3F;
      if (k == 1) return (ba >> 8) & 22'hFF;
      return ba & 22'hFE;
   endfunction

   function automatic logic [21:0] wbyte(input logic [21:0] ba, input int k, input logic [7:0] d);
      if (k == 0) return (ba & ~(22'h3F << 16)) | ((22'(d) & 22'h3F) << 16);
      if (k == 1) return (ba & ~(22'hFF << 8)) | (22'(d) << 8);
      return (ba & ~22'hFF) | (22'(d) & 22'hFE);
   endfunction

   function automatic logic [7:0] model_read(input logic [4:0] ra);
      int k = int'(ra);
      if (k == 0) return {6'b0, m_rep, m_on};
      if (k >= 1 && k <= 3) return rbyte(m_shb, k - 1);
      if (k >= 4 && k <= 6) return rbyte({snd, 1'b0}, k - 4);
      if (k >= 7 && k <= 9) return rbyte(m_sht, k - 7);
      if (k == 16) return {m_mono, 5'b0, m_rate};
      return 8'h00;
   endfunction

   task automatic push_status(input int c);
      st_t s;
      s = '{c, m_on, m_rep, m_mono, m_rate, m_sfb, m_sft};
      sq.push_back(s);
   endtask

   task automatic model_reset();
      m_on = 0; m_rep = 0; m_mono = 0; m_rate = RM;
      m_shb = '0; m_sht = '0; m_sfb = '0; m_sft = '0;
   endtask

   // one clock edge of the specified behaviour, effects visible in cycle c
   task automatic model_step(input int c, input bit w, input bit r, input logic [4:0] ra, input logic [7:0] d, input bit s);
      bit ctl, nrep, fr, si;
      rd_t rr;
      fr_t ff;
      ctl = w && ra == 5'd0;
      fr = 0;
      si = 0;
      if (r) begin
         rr = '{c, model_read(ra)};
         rq.push_back(rr);
      end
      nrep = ctl ? d[1] : m_rep;
      if (!m_on) begin
         if (ctl && d[0]) begin fr = 1; m_on = 1; end
      end else begin
         si = s;
         if (ctl && !d[0]) m_on = 0;
         else if (s && nrep) fr = 1;
         else if (s) m_on = 0;
      end
      if (fr) begin
         m_sfb = m_shb[21:1];
         m_sft = m_sht[21:1];
         ff = '{c, m_sfb, m_sft};
         fq.push_back(ff);
      end
      if (si) iq.push_back(c);
      m_rep = nrep;
      if (w) begin
         if (ra >= 5'd1 && ra <= 5'd3) m_shb = wbyte(m_shb, int'(ra) - 1, d);
         if (ra >= 5'd7 && ra <= 5'd9) m_sht = wbyte(m_sht, int'(ra) - 7, d);
         if (ra == 5'd16) begin m_rate = d[1:0]; m_mono = d[7]; end
      end
      push_status(c);
   endtask

   task automatic step(input bit rs, input bit w, input bit r, input logic [4:0] ra, input logic [7:0] d, input bit s);
      @(posedge clk32);
      #1;
      if (rs) begin
         resb = 0; we = 0; re = 0; send = 0;
         rq.delete(); fq.delete(); iq.delete(); sq.delete();
         model_reset();
         push_status(cyc);
         in_rst = 1;
      end else begin
         resb = 1; we = w; re = r; a = ra; din = d; send = s; snd = snd_v;
         if (in_rst) push_status(cyc);
         in_rst = 0;
         model_step(cyc + 1, w, r, ra, d, s);
      end
   endtask

   task automatic wr(input logic [4:0] ra, input logic [7:0] d); step(0, 1, 0, ra, d, 0); endtask
   task automatic rd(input logic [4:0] ra); step(0, 0, 1, ra, 8'h00, 0); endtask
   task automatic idle(input int n); for (int k = 0; k < n; k++) step(0, 0, 0, 5'd0, 8'h00, 0); endtask
   task automatic rst(input int n); for (int k = 0; k < n; k++) step(1, 0, 0, 5'd0, 8'h00, 0); endtask

   // monitor: pops expectations whenever the DUT presents a response
   always @(negedge clk32) begin
      while (rq.size() > 0 && rq[0].cyc < cyc) begin flag("read response missing"); void'(rq.pop_front()); end
      while (fq.size() > 0 && fq[0].cyc < cyc) begin flag("sframe missing"); void'(fq.pop_front()); end
      while (iq.size() > 0 && iq[0] < cyc) begin flag("sint missing"); void'(iq.pop_front()); end
      while (sq.size() > 0 && sq[0].cyc < cyc) void'(sq.pop_front());
      if (dout_oe) begin
         if (rq.size() > 0 && rq[0].cyc == cyc) begin
            check("dout", 32'(dout), 32'(rq[0].v));
            void'(rq.pop_front());
         end else flag("unexpected dout_oe");
      end
      if (sframe) begin
         if (fq.size() > 0 && fq[0].cyc == cyc) begin
            check("sfb at sframe", 32'(sfb), 32'(fq[0].b));
            check("sft at sframe", 32'(sft), 32'(fq[0].t));
            void'(fq.pop_front());
         end else flag("unexpected sframe");
      end
      if (sint) begin
         if (iq.size() > 0 && iq[0] == cyc) begin
            check("sint", 32'(sint), 32'd1);
            void'(iq.pop_front());
         end else flag("unexpected sint");
      end
      if (sq.size() > 0 && sq[0].cyc == cyc) begin
         check("sndon", 32'(sndon), 32'(sq[0].on));
         check("sfrep", 32'(sfrep), 32'(sq[0].rep));
         check("rate", 32'(rate), 32'(sq[0].rate));
         check("mono", 32'(mono), 32'(sq[0].mono));
         check("sfb", 32'(sfb), 32'(sq[0].b));
         check("sft", 32'(sft), 32'(sq[0].t));
         void'(sq.pop_front());
      end
   end

   initial begin
      logic [4:0] idx [11];
      logic [4:0] ra;
      idx = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd16};
      model_reset();
      #2 resb = 0;
      rst(2);
      for (int k = 0; k < 32; k++) rd(5'(k));
      wr(5'd1, 8'h01); wr(5'd2, 8'h23); wr(5'd3, 8'h45);
      wr(5'd7, 8'h01); wr(5'd8, 8'h30); wr(5'd9, 8'h00);
      rd(5'd1); rd(5'd2); rd(5'd3); rd(5'd7); rd(5'd8); rd(5'd9);
      wr(5'd0, 8'h01); idle(3);
      step(0, 0, 0, 5'd0, 8'h00, 1); idle(2); rd(5'd0);
      wr(5'd0, 8'h03); idle(2);
      wr(5'd1, 8'h02); wr(5'd2, 8'h00); wr(5'd3, 8'h00);
      step(0, 0, 0, 5'd0, 8'h00, 1); idle(2); rd(5'd0);
      step(0, 1, 0, 5'd0, 8'h02, 1); idle(2); rd(5'd0);
      wr(5'd0, 8'h01); idle(2); rst(1); idle(2);
      snd_v = 21'h0ABCD;
      rd(5'd4); rd(5'd5); rd(5'd6);
      rd(5'd16); wr(5'd16, 8'h83); rd(5'd16);
      wr(5'd7, 8'h3F); wr(5'd9, 8'hFF); rd(5'd7); rd(5'd9);
      for (int i = 0; i < 4000; i++) begin
         ra = ($urandom_range(0, 4) == 0) ? 5'($urandom) : idx[$urandom_range(0, 10)];
         snd_v = 21'($urandom);
         if ($urandom_range(0, 399) == 0) rst(1 + $urandom_range(0, 1));
         else step(0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, ra, 8'($urandom), $urandom_range(0, 7) == 0);
      end
      idle(3);
      @(posedge clk32);
      @(negedge clk32);
      check("pending responses drained", 32'(rq.size() + fq.size() + iq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
